tp_exec_unit: RTL

Parametrised memory-to-memory execute engine for the TP-ISA core. It accepts one decoded instruction word per handshake and performs the operand reads, the ALU operation, the flag update and the write-back. Reads and writes go over a single-port data-memory request/ack interface. It also evaluates branch conditions and keeps the base-address register (BAR) and the S/Z/C/V flags. Data width and address width are generalised beyond the fixed 8-bit first generation.

---
 rtl/tp_exec_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/tp_exec_unit.sv
// tp_exec_unit: memory-to-memory execute engine for the TP-ISA core.
// Accepts one decoded instruction per handshake. It reads the operands over a
// single-port request/ack memory interface, runs the ALU, updates the S/Z/C/V
// flags, writes the result back, evaluates branches and holds the BAR.
// Opcodes: 0 add, 1 and, 2 or, 3 xor, 4 not, 5 rl, 6 rr, 7 store,
//          8 br, 9 brn, A bp, F setbar; all others are nops.
// Branch condition fields sit in imm[4:0], so ADDR_W must be at least 5.
module tp_exec_unit #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      instr_valid,
   output logic                      instr_ready,
   input  logic [8+2*ADDR_W-1:0]     instr,
   output logic                      mem_req,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata,
   input  logic                      mem_ack,
   output logic                      br_taken,
   output logic [ADDR_W-1:0]         br_target,
   output logic [3:0]                flags,
   output logic [ADDR_W-1:0]         bar
);

   localparam int IW = 8 + 2*ADDR_W;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_AND    = 4'h1;
   localparam logic [3:0] OP_OR     = 4'h2;
   localparam logic [3:0] OP_XOR    = 4'h3;
   localparam logic [3:0] OP_NOT    = 4'h4;
   localparam logic [3:0] OP_RL     = 4'h5;
   localparam logic [3:0] OP_RR     = 4'h6;
   localparam logic [3:0] OP_STORE  = 4'h7;
   localparam logic [3:0] OP_BR     = 4'h8;
   localparam logic [3:0] OP_BRN    = 4'h9;
   localparam logic [3:0] OP_BP     = 4'hA;
   localparam logic [3:0] OP_SETBAR = 4'hF;

   typedef enum logic [2:0] {S_IDLE, S_RD1, S_RD2, S_EXEC, S_WR, S_BR} state_t;

   state_t              state, state_nx;
   logic [IW-1:0]       ir;
   logic [DATA_W-1:0]   op_a, op_b, res_q;
   logic [3:0]          flags_q;      // {S,Z,C,V}
   logic [ADDR_W-1:0]   bar_q;

   // Latched instruction fields; only these drive the operation after accept.
   logic [3:0]          op, in_op;
   logic                bm_w, bm_c, bm_s, bm_b;
   logic [ADDR_W-1:0]   a1, a2, ea1, ea2;
   logic                is_binary;
   logic [DATA_W-1:0]   imm_ext;

   assign op                      = ir[IW-1 -: 4];
   assign {bm_w, bm_c, bm_s, bm_b} = ir[IW-5 -: 4];
   assign a1                      = ir[2*ADDR_W-1 -: ADDR_W];
   assign a2                      = ir[ADDR_W-1:0];
   assign in_op                   = instr[IW-1 -: 4];
   assign ea1                     = bm_b ? a1 + bar_q : a1;
   assign ea2                     = bm_b ? a2 + bar_q : a2;
   assign is_binary               = (op == OP_ADD) || (op == OP_AND) ||
                                    (op == OP_OR)  || (op == OP_XOR);
   assign imm_ext                 = DATA_W'(a2);

   // ALU result, carry and overflow computed from the latched operands.
   logic [DATA_W:0]     alu_sum;
   logic [DATA_W-1:0]   alu_r;
   logic                alu_c, alu_v;

   // Combinational ALU evaluated during EXEC.
   always_comb begin
      alu_sum = {1'b0, op_a} + {1'b0, op_b} + {{DATA_W{1'b0}}, bm_c & flags_q[1]};
      alu_r   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            alu_r = alu_sum[DATA_W-1:0];
            alu_c = alu_sum[DATA_W];
            alu_v = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                    (alu_sum[DATA_W-1] != op_a[DATA_W-1]);
         end
         OP_AND: alu_r = op_a & op_b;
         OP_OR:  alu_r = op_a | op_b;
         OP_XOR: alu_r = op_a ^ op_b;
         OP_NOT: alu_r = ~op_a;
         OP_RL: begin
            alu_r = {op_a[DATA_W-2:0], op_a[DATA_W-1]};
            alu_c = op_a[DATA_W-1];
         end
         OP_RR: begin
            alu_r = {op_a[0], op_a[DATA_W-1:1]};
            alu_c = op_a[0];
         end
         default: alu_r = '0;
      endcase
   end

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic. Handshakes: instr transfers on a cycle with
   // instr_valid & instr_ready; a memory access holds mem_req/we/addr/wdata
   // until the cycle mem_ack is high, which completes it.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (instr_valid) begin
               case (in_op)
                  OP_ADD, OP_AND, OP_OR, OP_XOR,
                  OP_NOT, OP_RL, OP_RR:       state_nx = S_RD1;
                  OP_STORE:                   state_nx = S_WR;
                  OP_BR, OP_BRN, OP_BP:       state_nx = S_BR;
                  default:                    state_nx = S_IDLE;
               endcase
            end
         end
         S_RD1:   if (mem_ack) state_nx = is_binary ? S_RD2 : S_EXEC;
         S_RD2:   if (mem_ack) state_nx = S_EXEC;
         S_EXEC:  state_nx = bm_w ? S_WR : S_IDLE;
         S_WR:    if (mem_ack) state_nx = S_IDLE;
         S_BR:    state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath registers: instruction latch, operands, result, flags, BAR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ir      <= '0;
         op_a    <= '0;
         op_b    <= '0;
         res_q   <= '0;
         flags_q <= '0;
         bar_q   <= '0;
      end else begin
         if (state == S_IDLE && instr_valid) begin
            ir <= instr;
            if (in_op == OP_SETBAR) bar_q <= instr[2*ADDR_W-1 -: ADDR_W];
         end
         if (state == S_RD1 && mem_ack) op_a <= mem_rdata;
         if (state == S_RD2 && mem_ack) op_b <= mem_rdata;
         if (state == S_EXEC) begin
            res_q <= alu_r;
            if (bm_s) flags_q <= {alu_r[DATA_W-1], alu_r == '0, alu_c, alu_v};
         end
      end
   end

   // Outputs decoded from the current state and latched fields.
   always_comb begin
      instr_ready = (state == S_IDLE);
      mem_req     = (state == S_RD1) || (state == S_RD2) || (state == S_WR);
      mem_we      = (state == S_WR);
      mem_addr    = (state == S_RD2) ? ea2 : ea1;
      mem_wdata   = (op == OP_STORE) ? imm_ext : res_q;
      br_target   = ea1;
      br_taken    = 1'b0;
      if (state == S_BR) begin
         if (op == OP_BP) br_taken = 1'b1;
         else             br_taken = (|(flags_q & a2[3:0])) ^ a2[4];
      end
      flags       = flags_q;
      bar         = bar_q;
   end

endmodule
